sp_ram_initiator: RTL
=====================

// Module: sp_ram_initiator
// PURPOSE
//  Initiator side of the single-port RAM port (en/addr/wdata/we/be, 1-cycle read latency).
//  Converts a core-style req/gnt/rvalid load-store request (byte/half/word, any alignment)
//  into RAM accesses. Performs lane rotation, byte enables and sign/zero extension.
//  Splits misaligned accesses into two consecutive RAM words.
//  Sits between the core LSU and the data sp_ram instance.
// PARAMETERS
//  ADDR_WIDTH  8  byte-address width of the RAM port (word index = addr[ADDR_WIDTH-1:2])
// PORTS
//  clk          in   1           clock, all logic on rising edge
//  rst          in   1           synchronous, active-high reset
//  req_i        in   1           request valid; held with its attributes stable until gnt_o
//  addr_i       in   ADDR_WIDTH  byte address
//  we_i         in   1           1 = write, 0 = read
//  size_i       in   2           0 = byte, 1 = half, 2 = word, 3 = treated as word
//  sign_i       in   1           reads: 1 = sign-extend, 0 = zero-extend
//  wdata_i      in   32          write data, right-aligned
//  gnt_o        out  1           request accepted this cycle
//  rvalid_o     out  1           response strobe, one per granted request (reads and writes)
//  rdata_o      out  32          read data, right-aligned/extended; 0 for writes
//  ram_en_o     out  1           RAM enable
//  ram_addr_o   out  ADDR_WIDTH  RAM byte address, bits [1:0] always 0
//  ram_we_o     out  1           RAM write enable
//  ram_be_o     out  4           RAM byte enables
//  ram_wdata_o  out  32          RAM write data, lane-rotated
//  ram_rdata_i  in   32          RAM read data, valid the cycle after ram_en_o
// BEHAVIOUR
//  - Reset: state IDLE, response pipe cleared. gnt_o, rvalid_o, ram_en_o, ram_we_o = 0.
//    ram_be_o, ram_addr_o, ram_wdata_o, rdata_o = 0.
//  - off = addr_i[1:0]. mask = 0001/0011/1111 by size.
//    Misaligned iff (half && off==3) || (word && off!=0).
//  - Lane rule: ext_be = {4'b0,mask} << off (8 bits). ext_wd = wdata_i rotated left by 8*off.
//    The first word uses ext_be[3:0]; the second word uses ext_be[7:4].
//  - FSM IDLE, SPLIT:
//    IDLE, req_i aligned, at T: ram_en_o = 1 with word addr, be = ext_be[3:0], gnt_o = 1
//    combinationally in the same cycle. At T+1: rvalid_o = 1 and rdata_o is formatted.
//    Stays in IDLE, so back-to-back aligned requests run at 1 per cycle.
//    IDLE, req_i misaligned, at T: ram_en_o = 1 for the low word, gnt_o = 0. Latch addr, we,
//    size, sign and wdata, then go to SPLIT.
//    SPLIT, at T+1: ram_en_o = 1 for word+1 (mod 2^(ADDR_WIDTH-2)) with be = ext_be[7:4],
//    gnt_o = 1. Capture ram_rdata_i (low word) into a hold register, then go to IDLE.
//    At T+2: rvalid_o = 1. Read data = {ram_rdata_i, hold} >> 8*off, then masked and extended.
//  - SPLIT uses only the latched attributes. A change or drop of req_i there is a protocol
//    violation and is ignored; the access completes.
//  - A new request in the cycle after SPLIT is accepted normally.
//    The responses stay in order, one per cycle.
//  - ram_we_o = we for every issued access. Writes never touch lanes outside ext_be.
//  - Wrap: the word after the last RAM word is word 0. No error is signalled.
//  - Reset mid-SPLIT: return to IDLE with no gnt_o or rvalid_o. The low-half write issued at T
//    stays in the RAM (no rollback). A pending rvalid is dropped.
// STRUCTURE
//  - sp_ram_pkg: size_e enum (SZ_BYTE/SZ_HALF/SZ_WORD), state_e {IDLE,SPLIT},
//    function size_mask(size) returns 4 bits.
//  - Sub-module sp_ram_lane_align (combinational): write rotate/be generation and
//    read merge/shift/extend. The top level holds the FSM, the latch and the response pipe.
// TESTING (bench uses a real sp_ram behind the initiator)
//  1. Word write 0xDEADBEEF @0x10, then word read @0x10:
//     be = 1111, gnt same cycle, rvalid +1, rdata = 0xDEADBEEF.
//  2. Byte write 0x80 @0x05, then byte read sign_i = 1: be = 0010, wdata lane1 = 0x80,
//     rdata = 0xFFFFFF80. With sign_i = 0: 0x00000080.
//  3. Word write 0x11223344 @0x02: two RAM cycles, addr 0x00 be = 1100 then addr 0x04
//     be = 0011. gnt only in cycle 2. The word read @0x02 returns 0x11223344 at T+2.
//  4. Half read @0x03 (size 1): split across words 0 and 1, rdata = {mem[4], mem[3]} extended.
//  5. Six back-to-back aligned reads: gnt each cycle, six rvalids in order, no bubbles.
//  6. Reset asserted in SPLIT of a misaligned write: no gnt or rvalid.
//     The low bytes are written, the high word is unchanged, and the next request works.
//  7. Misaligned word @last word + 2: second access to word 0 (wrap).

Source files
------------

// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the single-port RAM initiator.
package sp_ram_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    // Size code 3 falls into the default branch and behaves as a word.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        is_misaligned = ((size == SZ_HALF) && (off == 2'd3)) || (size[1] && (off != 2'd0));
    endfunction

endpackage

// File: rtl/sp_ram_lane_align.sv
// Combinational lane steering: write rotate / byte enables, read merge / shift / extend.
module sp_ram_lane_align
    import sp_ram_pkg::*;
(
    input  logic [1:0]  wr_off,
    input  logic [1:0]  wr_size,
    input  logic [31:0] wr_data,
    output logic [7:0]  ext_be,
    output logic [31:0] ext_wd,
    input  logic [1:0]  rd_off,
    input  logic [1:0]  rd_size,
    input  logic        rd_sign,
    input  logic [31:0] rd_lo,
    input  logic [31:0] rd_hi,
    output logic [31:0] rd_data
);

    logic [31:0] shifted;

    always_comb begin
        ext_be = {4'b0000, size_mask(wr_size)} << wr_off;
        case (wr_off)
            2'd0:    ext_wd = wr_data;
            2'd1:    ext_wd = {wr_data[23:0], wr_data[31:24]};
            2'd2:    ext_wd = {wr_data[15:0], wr_data[31:16]};
            default: ext_wd = {wr_data[7:0],  wr_data[31:8]};
        endcase
    end

    // The two RAM words form a 64-bit window; the access starts at byte rd_off of it.
    always_comb begin
        shifted = 32'({rd_hi, rd_lo} >> {rd_off, 3'b000});
        case (rd_size)
            SZ_BYTE: rd_data = {{24{rd_sign & shifted[7]}}, shifted[7:0]};
            SZ_HALF: rd_data = {{16{rd_sign & shifted[15]}}, shifted[15:0]};
            default: rd_data = shifted;
        endcase
    end

endmodule

// File: rtl/sp_ram_initiator.sv
// Core req/gnt/rvalid load-store port to single-port RAM; splits misaligned accesses in two.
module sp_ram_initiator
    import sp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  sign_i,
    input  logic [31:0]           wdata_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    localparam int WORD_W = ADDR_WIDTH - 2;

    state_e                state, state_nxt;
    logic                  latch;

    logic [ADDR_WIDTH-1:0] l_addr;
    logic                  l_we;
    logic [1:0]            l_size;
    logic                  l_sign;
    logic [31:0]           l_wdata;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_we;
    logic [1:0]            cur_size;
    logic                  cur_sign;
    logic [31:0]           cur_wdata;
    logic [WORD_W-1:0]     word, word_inc;
    logic                  mis;

    logic                  p_valid, p_we, p_sign, p_split;
    logic [1:0]            p_off, p_size;
    logic [31:0]           hold;

    logic [7:0]            ext_be;
    logic [31:0]           ext_wd, rd_fmt, rd_lo;

    // SPLIT works purely from the latched copy, so req_i changes there are ignored.
    always_comb begin
        if (state == SPLIT) begin
            cur_addr  = l_addr;
            cur_we    = l_we;
            cur_size  = l_size;
            cur_sign  = l_sign;
            cur_wdata = l_wdata;
        end else begin
            cur_addr  = addr_i;
            cur_we    = we_i;
            cur_size  = size_i;
            cur_sign  = sign_i;
            cur_wdata = wdata_i;
        end
        word     = cur_addr[ADDR_WIDTH-1:2];
        word_inc = word + WORD_W'(1);
        mis      = is_misaligned(cur_size, cur_addr[1:0]);
    end

    assign rd_lo = p_split ? hold : ram_rdata_i;

    sp_ram_lane_align u_align (
        .wr_off  (cur_addr[1:0]),
        .wr_size (cur_size),
        .wr_data (cur_wdata),
        .ext_be  (ext_be),
        .ext_wd  (ext_wd),
        .rd_off  (p_off),
        .rd_size (p_size),
        .rd_sign (p_sign),
        .rd_lo   (rd_lo),
        .rd_hi   (ram_rdata_i),
        .rd_data (rd_fmt)
    );

    always_comb begin
        state_nxt   = state;
        latch       = 1'b0;
        gnt_o       = 1'b0;
        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        ram_be_o    = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        ram_en_o   = 1'b1;
                        ram_addr_o = {word, 2'b00};
                        ram_be_o   = ext_be[3:0];
                        if (mis) begin
                            latch     = 1'b1;
                            state_nxt = SPLIT;
                        end else begin
                            gnt_o = 1'b1;
                        end
                    end
                end
                SPLIT: begin
                    ram_en_o   = 1'b1;
                    ram_addr_o = {word_inc, 2'b00};
                    ram_be_o   = ext_be[7:4];
                    gnt_o      = 1'b1;
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
        ram_we_o    = ram_en_o & cur_we;
        ram_wdata_o = ram_en_o ? ext_wd : '0;
    end

    assign rvalid_o = p_valid & ~rst;
    assign rdata_o  = (rvalid_o && !p_we) ? rd_fmt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            l_addr  <= '0;
            l_we    <= 1'b0;
            l_size  <= '0;
            l_sign  <= 1'b0;
            l_wdata <= '0;
            p_valid <= 1'b0;
            p_we    <= 1'b0;
            p_sign  <= 1'b0;
            p_split <= 1'b0;
            p_off   <= '0;
            p_size  <= '0;
            hold    <= '0;
        end else begin
            state   <= state_nxt;
            p_valid <= gnt_o;
            p_split <= (state == SPLIT);
            if (latch) begin
                l_addr  <= addr_i;
                l_we    <= we_i;
                l_size  <= size_i;
                l_sign  <= sign_i;
                l_wdata <= wdata_i;
            end
            if (gnt_o) begin
                p_we   <= cur_we;
                p_sign <= cur_sign;
                p_off  <= cur_addr[1:0];
                p_size <= cur_size;
            end
            if (state == SPLIT) begin
                hold <= ram_rdata_i;
            end
        end
    end

endmodule
